// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-triggered, fixed-priority interrupt controller with CPU acknowledge handshake
//   clk, rst        clock; asynchronous active-high reset
//   irqLines        raw interrupt sources, rising-edge sensitive
//   turnOffIRQ      CPU acknowledge of the presented interrupt
//   irq             interrupt request to CPU
//   intAddr         handler address (base + index*4)
//   intData         index of presented source, zero-extended
//   cfgWE, cfgAddr, cfgData, cfgRead
//                   config port: 0 mask, 1 base low, 2 base high, 3 pending (write-1-to-clear)
module interrupt_controller #(
    parameter int M = 16,
    parameter int N = 32,
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irqLines,
    input  logic               turnOffIRQ,
    output logic               irq,
    output logic [N-1:0]       intAddr,
    output logic [M-1:0]       intData,
    input  logic               cfgWE,
    input  logic [1:0]         cfgAddr,
    input  logic [M-1:0]       cfgData,
    output logic [M-1:0]       cfgRead
);
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} stateT;

    stateT              state;
    logic [NUM_IRQ-1:0] mask, pending, irqPrev, edges, candidates, ackClr, wrClr;
    logic [15:0]        baseLo, baseHi, wrData;
    logic               armed;
    logic [IW-1:0]      selIdx, latIdx;
    logic [N-1:0]       vecAddr;

    // armed stays low for the first cycle after reset so a line already high
    // during reset is not mistaken for a fresh edge
    assign edges      = armed ? irqLines & ~irqPrev : '0;
    assign candidates = pending & mask;
    assign wrData     = 16'(cfgData);
    assign wrClr      = (cfgWE && cfgAddr == 2'd3) ? cfgData[NUM_IRQ-1:0] : '0;
    assign ackClr     = (state == REQ && turnOffIRQ) ? NUM_IRQ'(1) << latIdx : '0;
    assign vecAddr    = N'({baseHi, baseLo}) + N'({selIdx, 2'b00});

    // scan from the top so the lowest set candidate is the last assignment
    always_comb begin
        selIdx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (candidates[i]) selIdx = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '0;
            baseLo  <= '0;
            baseHi  <= '0;
            pending <= '0;
            irqPrev <= '0;
            armed   <= 1'b0;
            cfgRead <= '0;
        end else begin
            irqPrev <= irqLines;
            armed   <= 1'b1;
            // a new edge beats any clear on the same bit
            pending <= (pending & ~(wrClr | ackClr)) | edges;
            if (cfgWE && cfgAddr == 2'd0) mask <= cfgData[NUM_IRQ-1:0];
            if (cfgWE && cfgAddr == 2'd1) baseLo <= wrData;
            if (cfgWE && cfgAddr == 2'd2) baseHi <= wrData;
            cfgRead <= cfgAddr == 2'd0 ? M'(mask) :
                       cfgAddr == 2'd1 ? M'(baseLo) :
                       cfgAddr == 2'd2 ? M'(baseHi) : M'(pending);
        end
    end

    // outputs latch on REQ entry and are frozen until the acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq     <= 1'b0;
            intAddr <= '0;
            intData <= '0;
            latIdx  <= '0;
        end else begin
            case (state)
                IDLE: if (|candidates) begin
                    state   <= REQ;
                    irq     <= 1'b1;
                    intAddr <= vecAddr;
                    intData <= M'(selIdx);
                    latIdx  <= selIdx;
                end
                REQ: if (turnOffIRQ) begin
                    state <= HOLD;
                    irq   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed, table-driven and randomized checks of interrupt_controller against a reference model
module tb_interrupt_controller;
    localparam int M = 16;
    localparam int N = 32;
    localparam int NI = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] irqLines = '0;
    logic          turnOffIRQ = 1'b0;
    logic          cfgWE = 1'b0;
    logic [1:0]    cfgAddr = '0;
    logic [M-1:0]  cfgData = '0;
    logic          irq;
    logic [N-1:0]  intAddr;
    logic [M-1:0]  intData;
    logic [M-1:0]  cfgRead;

    interrupt_controller #(.M(M), .N(N), .NUM_IRQ(NI)) dut (
        .clk(clk), .rst(rst), .irqLines(irqLines), .turnOffIRQ(turnOffIRQ),
        .irq(irq), .intAddr(intAddr), .intData(intData),
        .cfgWE(cfgWE), .cfgAddr(cfgAddr), .cfgData(cfgData), .cfgRead(cfgRead)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    // reference model: mode 0 = nothing presented, 1 = presenting, 2 = forced gap
    logic [NI-1:0] mPend, mMask, mPrev;
    logic [31:0]   mBase, mAddr;
    logic [15:0]   mRead;
    bit            mArmed, mIrq;
    int            mMode, mIdx;

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } regVecT;
    regVecT regVecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPend = '0; mMask = '0; mPrev = '0; mBase = '0; mAddr = '0;
        mRead = '0; mArmed = 0; mIrq = 0; mMode = 0; mIdx = 0;
    endtask

    task automatic modelEdge();
        logic [NI-1:0] edges, cand, clr;
        logic [15:0]   rd;
        int            pick;
        case (cfgAddr)
            2'd0: rd = 16'(mMask);
            2'd1: rd = mBase[15:0];
            2'd2: rd = mBase[31:16];
            default: rd = 16'(mPend);
        endcase
        edges = mArmed ? (irqLines & ~mPrev) : '0;
        cand = mPend & mMask;
        clr = (cfgWE && cfgAddr == 2'd3) ? cfgData[NI-1:0] : '0;
        if (mMode == 0) begin
            pick = -1;
            for (int i = 0; i < NI; i++)
                if (cand[i]) begin
                    pick = i;
                    break;
                end
            if (pick >= 0) begin
                mMode = 1; mIdx = pick; mIrq = 1;
                mAddr = mBase + 32'(pick * 4);
            end
        end else if (mMode == 1) begin
            if (turnOffIRQ) begin
                mMode = 2; mIrq = 0; clr[mIdx] = 1'b1;
            end
        end else mMode = 0;
        mPend = (mPend & ~clr) | edges;
        if (cfgWE)
            case (cfgAddr)
                2'd0: mMask = cfgData[NI-1:0];
                2'd1: mBase[15:0] = cfgData;
                2'd2: mBase[31:16] = cfgData;
                default: ;
            endcase
        mPrev = irqLines;
        mArmed = 1;
        mRead = rd;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) modelReset(); else modelEdge();
        #1;
        check("irq", 32'(irq), 32'(mIrq));
        if (mIrq) begin
            check("intAddr", intAddr, mAddr);
            check("intData", 32'(intData), 32'(mIdx));
        end
        check("cfgRead", 32'(cfgRead), 32'(mRead));
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfgWE = 1'b1; cfgAddr = a; cfgData = d;
        step();
        cfgWE = 1'b0;
    endtask

    task automatic ack();
        turnOffIRQ = 1'b1;
        step();
        turnOffIRQ = 1'b0;
    endtask

    initial begin
        regVecs[0] = '{2'd0, 16'h01FF, 16'h00FF};
        regVecs[1] = '{2'd1, 16'h1234, 16'h1234};
        regVecs[2] = '{2'd2, 16'hABCD, 16'hABCD};
        regVecs[3] = '{2'd0, 16'h0000, 16'h0000};
        regVecs[4] = '{2'd3, 16'hFFFF, 16'h0000};

        modelReset();
        #2 rst = 1'b1;
        step();
        step();
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_intAddr", intAddr, 32'h0);
        check("rst_intData", 32'(intData), 32'h0);
        check("rst_cfgRead", 32'(cfgRead), 32'h0);
        rst = 1'b0;
        step();

        // register write / read-back table
        for (int i = 0; i < 5; i++) begin
            wr(regVecs[i].addr, regVecs[i].data);
            step();
            check("regRead", 32'(cfgRead), 32'(regVecs[i].exp));
        end

        // single source, vector base 0x0001_0000
        wr(0, 16'h0001); wr(1, 16'h0000); wr(2, 16'h0001);
        irqLines = 8'h01;
        step();
        check("s1_notYet", 32'(irq), 32'h0);
        step();
        check("s1_irq", 32'(irq), 32'h1);
        check("s1_addr", intAddr, 32'h0001_0000);
        check("s1_data", 32'(intData), 32'h0);
        irqLines = 8'h00;
        ack();
        check("s1_ackLow", 32'(irq), 32'h0);
        cfgAddr = 2'd3;
        step();
        check("s1_pend", 32'(cfgRead), 32'h0);

        // two simultaneous edges, lowest index first, gap between requests
        wr(0, 16'h00FF); wr(1, 16'h1000); wr(2, 16'h0000);
        irqLines = 8'h24;
        step();
        step();
        check("s2_addr2", intAddr, 32'h0000_1008);
        check("s2_data2", 32'(intData), 32'h2);
        irqLines = 8'h00;
        ack();
        step();
        check("s2_holdLow", 32'(irq), 32'h0);
        step();
        check("s2_irq5", 32'(irq), 32'h1);
        check("s2_addr5", intAddr, 32'h0000_1014);
        check("s2_data5", 32'(intData), 32'h5);
        ack();
        step();
        step();

        // masked edge still pends; mask write uses old mask; W1C during REQ
        wr(0, 16'h0000);
        irqLines = 8'h08;
        step();
        irqLines = 8'h00;
        step();
        step();
        check("s3_masked", 32'(irq), 32'h0);
        cfgAddr = 2'd3;
        step();
        check("s3_pend", 32'(cfgRead), 32'h0008);
        wr(0, 16'h0008);
        check("s3_oldMask", 32'(irq), 32'h0);
        step();
        check("s3_irq", 32'(irq), 32'h1);
        check("s3_data", 32'(intData), 32'h3);
        wr(3, 16'h0008);
        check("s3_w1cHeld", 32'(irq), 32'h1);
        step();
        check("s3_stillHeld", 32'(irq), 32'h1);
        check("s3_pendClr", 32'(cfgRead), 32'h0);
        ack();
        step();
        step();
        check("s3_noRepeat", 32'(irq), 32'h0);

        // vector address wraps
        wr(0, 16'h0002); wr(1, 16'hFFFC); wr(2, 16'hFFFF);
        irqLines = 8'h02;
        step();
        irqLines = 8'h00;
        step();
        check("s4_irq", 32'(irq), 32'h1);
        check("s4_wrap", intAddr, 32'h0000_0000);
        ack();
        step();
        step();

        // new edge coincides with ack of the same index
        wr(0, 16'h0001);
        irqLines = 8'h01;
        step();
        irqLines = 8'h00;
        step();
        check("s5_first", 32'(irq), 32'h1);
        irqLines = 8'h01;
        ack();
        irqLines = 8'h00;
        step();
        check("s5_hold", 32'(irq), 32'h0);
        step();
        check("s5_again", 32'(irq), 32'h1);
        check("s5_data", 32'(intData), 32'h0);
        ack();
        step();
        step();

        // async reset during REQ, line held high across release
        wr(0, 16'h0010);
        irqLines = 8'h10;
        step();
        step();
        check("s6_irq", 32'(irq), 32'h1);
        check("s6_data", 32'(intData), 32'h4);
        rst = 1'b1;
        #1;
        check("s6_asyncDrop", 32'(irq), 32'h0);
        modelReset();
        step();
        rst = 1'b0;
        cfgAddr = 2'd3;
        step();
        wr(0, 16'h0010);
        cfgAddr = 2'd3;
        step();
        step();
        check("s6_noIrq", 32'(irq), 32'h0);
        check("s6_noPend", 32'(cfgRead), 32'h0);
        irqLines = 8'h00;
        step();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++)
                if ($urandom_range(7) == 0) irqLines[i] = ~irqLines[i];
            turnOffIRQ = ($urandom_range(3) == 0);
            cfgWE = ($urandom_range(5) == 0);
            cfgAddr = 2'($urandom_range(3));
            cfgData = 16'($urandom);
            step();
        end
        cfgWE = 1'b0;
        turnOffIRQ = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
